// File: rtl/adc_pkg.sv
// ============================================================================
// Module   : adc_pkg
// Brief    : Shared constants and lane-slice helper for the ADC deserializer.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

package adc_pkg;

    localparam int ADC_DATA_W = 15;
    localparam int ADC_NUM_CH = 4;

    // Lane k occupies [lane_lsb(k) +: data_w] of the packed output word.
    function automatic int lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_lane_shift.sv
// ============================================================================
// Module   : adc_lane_shift
// Brief    : One serial lane shift register; word shows the value including
//            the bit being shifted in this cycle.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

module adc_lane_shift #(
    parameter int DATA_W    = 15,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              clr,
    input  logic              bit_in,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_next;

    // A frame restart drops the stale partial word before the new bit lands.
    always_comb begin
        w_base = clr ? '0 : r_sr;
        if (MSB_FIRST) begin
            w_next = {w_base[DATA_W-2:0], bit_in};
        end else begin
            w_next = {bit_in, w_base[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (shift_en) begin
            r_sr <= w_next;
        end else if (clr) begin
            r_sr <= '0;
        end
    end

    assign word = w_next;

endmodule

`default_nettype wire

// File: rtl/adc_multi_parser.sv
// ============================================================================
// Module   : adc_multi_parser
// Brief    : NUM_CH-lane serial ADC deserializer with frame realignment and a
//            valid/ready output register with overflow and frame-error flags.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

module adc_multi_parser
    import adc_pkg::*;
#(
    parameter int NUM_CH    = ADC_NUM_CH,
    parameter int DATA_W    = ADC_DATA_W,
    parameter int MSB_FIRST = 1,
    parameter int USE_FRAME = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [NUM_CH-1:0]        bits_i,
    input  logic                     frame_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [NUM_CH*DATA_W-1:0] data_o,
    output logic                     frame_err_o,
    output logic                     overflow_o,
    output logic [15:0]              word_cnt_o
);

    localparam int                 c_cnt_w = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_W - 1);

    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_cnt_w-1:0]       w_cnt_nxt;
    logic                     w_frame;
    logic                     w_complete;
    logic                     w_accept;
    logic                     w_ferr;
    logic [NUM_CH*DATA_W-1:0] w_words;

    logic                     r_valid;
    logic [NUM_CH*DATA_W-1:0] r_data;
    logic                     r_ferr;
    logic                     r_ovf;
    logic [15:0]              r_wcnt;

    assign w_frame    = (USE_FRAME != 0) && valid_i && frame_i;
    assign w_complete = valid_i && !w_frame && (r_cnt == c_last);
    assign w_accept   = r_valid && ready_i;
    assign w_ferr     = w_frame && (r_cnt != '0);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
            adc_lane_shift #(
                .DATA_W    (DATA_W),
                .MSB_FIRST (MSB_FIRST != 0)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .shift_en (valid_i),
                .clr      (w_frame),
                .bit_in   (bits_i[k]),
                .word     (w_words[lane_lsb(k, DATA_W) +: DATA_W])
            );
        end
    endgenerate

    // A frame strobe carries bit 0 itself, so counting resumes at 1.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_frame) begin
            w_cnt_nxt = c_cnt_w'(1);
        end else if (valid_i) begin
            w_cnt_nxt = (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_ferr <= w_ferr;
            if (w_accept) begin
                r_wcnt <= r_wcnt + 16'd1;
            end
            // A new word may refill the register in the same cycle it drains.
            if (w_complete) begin
                if (r_valid && !ready_i) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_data  <= w_words;
                    r_valid <= 1'b1;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o     = r_valid;
    assign data_o      = r_data;
    assign frame_err_o = r_ferr;
    assign overflow_o  = r_ovf;
    assign word_cnt_o  = r_wcnt;

endmodule

`default_nettype wire

// File: tb/tb_adc_multi_parser.sv
// ============================================================================
// Module   : tb_adc_multi_parser
// Brief    : Two DUT flavours (MSB-first framed, LSB-first free-running) driven
//            by shared stimulus and checked against a bit-list reference model.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

module tb_adc_multi_parser;

    localparam int DW = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        frame_i;
    logic        ready_i;
    logic [2:0]  bits_i;

    logic        a_valid, a_ferr, a_ovf;
    logic [29:0] a_data;
    logic [15:0] a_wcnt;
    logic        b_valid, b_ferr, b_ovf;
    logic [44:0] b_data;
    logic [15:0] b_wcnt;

    always #5 clk = ~clk;

    adc_multi_parser #(.NUM_CH(2), .DATA_W(DW), .MSB_FIRST(1), .USE_FRAME(1)) u_dut_a (
        .clk(clk), .rst(rst), .valid_i(valid_i), .bits_i(bits_i[1:0]), .frame_i(frame_i),
        .ready_i(ready_i), .valid_o(a_valid), .data_o(a_data), .frame_err_o(a_ferr),
        .overflow_o(a_ovf), .word_cnt_o(a_wcnt));

    adc_multi_parser #(.NUM_CH(3), .DATA_W(DW), .MSB_FIRST(0), .USE_FRAME(0)) u_dut_b (
        .clk(clk), .rst(rst), .valid_i(valid_i), .bits_i(bits_i), .frame_i(frame_i),
        .ready_i(ready_i), .valid_o(b_valid), .data_o(b_data), .frame_err_o(b_ferr),
        .overflow_o(b_ovf), .word_cnt_o(b_wcnt));

    // Reference model: each lane collects a plain list of received bits and a
    // word is assembled from that list once DW bits have arrived.
    int          m_nch [2] = '{2, 3};
    bit          m_msb [2] = '{1'b1, 1'b0};
    bit          m_uf  [2] = '{1'b1, 1'b0};
    int          n     [2] = '{0, 0};
    bit          hist  [2][3][DW];
    logic        m_valid [2];
    logic        m_ferr  [2];
    logic        m_ovf   [2];
    logic [44:0] m_data  [2];
    logic [15:0] m_wcnt  [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int a_ferr_cnt = 0;

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit          accept;
            bit          done;
            logic [44:0] w;
            if (rst) begin
                n[m] = 0;
                m_valid[m] = 1'b0;
                m_ferr[m]  = 1'b0;
                m_ovf[m]   = 1'b0;
                m_data[m]  = '0;
                m_wcnt[m]  = '0;
            end else begin
                accept = m_valid[m] && ready_i;
                done = 1'b0;
                w = '0;
                m_ferr[m] = 1'b0;
                if (valid_i) begin
                    if (m_uf[m] && frame_i) begin
                        m_ferr[m] = (n[m] != 0);
                        n[m] = 0;
                    end
                    for (int k = 0; k < m_nch[m]; k++) hist[m][k][n[m]] = bits_i[k];
                    n[m]++;
                    if (n[m] == DW) begin
                        done = 1'b1;
                        n[m] = 0;
                        for (int k = 0; k < m_nch[m]; k++)
                            for (int i = 0; i < DW; i++)
                                w[k*DW + (m_msb[m] ? DW-1-i : i)] = hist[m][k][i];
                    end
                end
                if (done) begin
                    if (m_valid[m] && !ready_i) begin
                        m_ovf[m] = 1'b1;
                    end else begin
                        m_data[m]  = w;
                        m_valid[m] = 1'b1;
                    end
                end else if (accept) begin
                    m_valid[m] = 1'b0;
                end
                if (accept) m_wcnt[m] = m_wcnt[m] + 16'd1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_valid", 64'(a_valid), 64'(m_valid[0]));
            chk("a_data",  64'(a_data),  64'(m_data[0][29:0]));
            chk("a_ferr",  64'(a_ferr),  64'(m_ferr[0]));
            chk("a_ovf",   64'(a_ovf),   64'(m_ovf[0]));
            chk("a_wcnt",  64'(a_wcnt),  64'(m_wcnt[0]));
            chk("b_valid", 64'(b_valid), 64'(m_valid[1]));
            chk("b_data",  64'(b_data),  64'(m_data[1]));
            chk("b_ferr",  64'(b_ferr),  64'(m_ferr[1]));
            chk("b_ovf",   64'(b_ovf),   64'(m_ovf[1]));
            chk("b_wcnt",  64'(b_wcnt),  64'(m_wcnt[1]));
            if (a_ferr) a_ferr_cnt++;
        end
    end

    task automatic tick(input logic v, input logic f, input logic r, input logic [2:0] b);
        valid_i = v;
        frame_i = f;
        ready_i = r;
        bits_i  = b;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 3'b000);
        tick(1'b0, 1'b0, 1'b0, 3'b000);
        rst = 1'b0;
    endtask

    task automatic send(input logic [14:0] w0, input logic [14:0] w1, input logic [14:0] w2,
                        input bit msb, input bit frm, input logic rdy, input logic rdy_last,
                        input bit gap);
        int p;
        for (int i = 0; i < DW; i++) begin
            p = msb ? DW-1-i : i;
            if (gap && ($urandom_range(0, 1) == 1)) tick(1'b0, 1'b0, rdy, 3'($urandom));
            tick(1'b1, frm && (i == 0), (i == DW-1) ? rdy_last : rdy, {w2[p], w1[p], w0[p]});
        end
    endtask

    initial begin
        int f0;
        rst = 1'b1;
        valid_i = 1'b0;
        frame_i = 1'b0;
        ready_i = 1'b0;
        bits_i  = '0;
        do_reset();
        chk_en = 1'b1;
        chk("lit reset a_valid", 64'(a_valid), 64'd0);
        chk("lit reset a_data",  64'(a_data),  64'd0);
        chk("lit reset a_wcnt",  64'(a_wcnt),  64'd0);
        chk("lit reset b_valid", 64'(b_valid), 64'd0);

        // MSB-first word on two lanes, continuous strobes
        send(15'h5A5A, 15'h1234, 15'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lit msb a_valid", 64'(a_valid), 64'd1);
        chk("lit msb a_data",  64'(a_data),  64'({15'h1234, 15'h5A5A}));
        tick(1'b0, 1'b0, 1'b1, 3'b000);
        chk("lit msb a_valid drop", 64'(a_valid), 64'd0);
        chk("lit msb a_wcnt",       64'(a_wcnt),  64'd1);

        // LSB-first word with gapped strobes, seen by the LSB-first flavour
        send(15'h5A5A, 15'h0000, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("lit lsb b_valid", 64'(b_valid),       64'd1);
        chk("lit lsb b_data",  64'(b_data[14:0]),  64'h5A5A);
        tick(1'b0, 1'b0, 1'b1, 3'b000);

        // Frame at bit 0, then again at bit 6
        f0 = a_ferr_cnt;
        tick(1'b1, 1'b1, 1'b1, 3'($urandom));
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1, 3'($urandom));
        send(15'h3C3C, 15'h0F0F, 15'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lit misalign ferr pulses", 64'(a_ferr_cnt - f0), 64'd1);
        chk("lit misalign a_valid",     64'(a_valid), 64'd1);
        chk("lit misalign a_data",      64'(a_data),  64'({15'h0F0F, 15'h3C3C}));
        tick(1'b0, 1'b0, 1'b1, 3'b000);

        // Backpressure: second word dropped, overflow sticky
        do_reset();
        send(15'h0001, 15'h0000, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit bp first valid", 64'(a_valid), 64'd1);
        send(15'h0002, 15'h0000, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit bp ovf",  64'(a_ovf),  64'd1);
        chk("lit bp data", 64'(a_data), 64'h1);
        tick(1'b0, 1'b0, 1'b0, 3'b000);
        chk("lit bp ovf sticky", 64'(a_ovf), 64'd1);
        tick(1'b0, 1'b0, 1'b1, 3'b000);
        chk("lit bp drained", 64'(a_valid), 64'd0);
        chk("lit bp wcnt",    64'(a_wcnt),  64'd1);
        chk("lit bp ovf held", 64'(a_ovf),  64'd1);

        // Accept and refill in the same cycle
        do_reset();
        send(15'h0123, 15'h0000, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(15'h7FFF, 15'h0000, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("lit refill valid", 64'(a_valid), 64'd1);
        chk("lit refill data",  64'(a_data),  64'h7FFF);
        chk("lit refill ovf",   64'(a_ovf),   64'd0);
        chk("lit refill wcnt",  64'(a_wcnt),  64'd1);
        tick(1'b0, 1'b0, 1'b1, 3'b000);

        // Reset in the middle of a word
        tick(1'b1, 1'b1, 1'b1, 3'($urandom));
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1, 3'($urandom));
        do_reset();
        chk("lit midrst a_valid", 64'(a_valid), 64'd0);
        chk("lit midrst a_data",  64'(a_data),  64'd0);
        chk("lit midrst a_ovf",   64'(a_ovf),   64'd0);
        chk("lit midrst a_wcnt",  64'(a_wcnt),  64'd0);
        chk("lit midrst b_data",  64'(b_data),  64'd0);
        send(15'h2D2D, 15'h1111, 15'h2222, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lit midrst word valid", 64'(a_valid), 64'd1);
        chk("lit midrst word data",  64'(a_data),  64'({15'h1111, 15'h2D2D}));
        chk("lit midrst word ferr",  64'(a_ferr),  64'd0);

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            tick(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 9) < 7), 3'($urandom));
        end

        tick(1'b0, 1'b0, 1'b1, 3'b000);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adc_multi_parser.md
Name: adc_multi_parser

Overview:
- Parametrised multi-lane successor to the single-lane serial ADC deserializer.
- Deserializes NUM_CH parallel serial ADC bitstreams that share one bit-valid strobe, with selectable bit order and optional frame-sync realignment.
- Presents completed words on a valid/ready output register, with overflow and frame-error reporting.
- Sits between the ADC pin-capture logic and the readout FIFO/packetizer.

Parameters:
- NUM_CH, 4, number of serial lanes deserialized in lockstep (1..16).
- DATA_W, 15, bits per ADC word (2..32).
- MSB_FIRST, 1, 1 = first received bit is word MSB; 0 = first received bit is LSB.
- USE_FRAME, 1, 1 = frame_i realigns the bit counter; 0 = frame_i ignored, free-running count.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- valid_i  input  1  bit strobe; bits_i sampled only when high
- bits_i  input  NUM_CH  one serial bit per lane
- frame_i  input  1  qualified by valid_i; marks the current bit as bit 0 of a new word
- ready_i  input  1  downstream accepts data_o when valid_o && ready_i
- valid_o  output  1  output word register holds an unconsumed word
- data_o  output  NUM_CH*DATA_W  lane k occupies [k*DATA_W +: DATA_W]
- frame_err_o  output  1  one-cycle pulse: frame_i arrived with bit count != 0
- overflow_o  output  1  sticky: a completed word was dropped; cleared only by rst
- word_cnt_o  output  16  count of words accepted downstream, wraps at 2^16

Behaviour:
- Reset: all shift registers, bit counter, data_o, valid_o, frame_err_o, overflow_o and word_cnt_o go to 0. Reset mid-word discards the partial word.
- Bit counter cnt, width $clog2(DATA_W):
  - Advances only on valid_i.
  - On valid_i with cnt == DATA_W-1, the word is complete and cnt returns to 0.
- Shift, per lane:
  - MSB_FIRST=1: sr <= {sr[DATA_W-2:0], bit}.
  - MSB_FIRST=0: sr <= {bit, sr[DATA_W-1:1]}.
- Completion: the completed word includes the current bit. It is loaded into data_o, and valid_o asserts in the following cycle, i.e. latency is 1 clk after the final bit strobe.
- Frame sync (USE_FRAME=1), on valid_i && frame_i:
  - The current bit becomes bit 0 and cnt <= 1 (DATA_W=1 is not supported).
  - If the prior cnt != 0, frame_err_o pulses for 1 cycle and the partial word is discarded.
  - frame_i with cnt == 0 is a normal aligned start with no error.
  - frame_i without valid_i is ignored.
- Output handshake:
  - valid_o falls after a cycle with valid_o && ready_i, unless a new word completes in the same cycle.
  - If a new word completes in that same cycle, data_o is replaced and valid_o stays 1.
  - data_o is stable while valid_o && !ready_i.
- Overflow: a word completes while valid_o && !ready_i.
  - The new word is dropped and the old data_o is retained.
  - overflow_o sets to 1.
- word_cnt_o increments on every valid_o && ready_i cycle.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package adc_pkg:
  - default constants ADC_DATA_W=15 and ADC_NUM_CH=4;
  - a function for the lane slice offset.
- Sub-module adc_lane_shift (params DATA_W, MSB_FIRST):
  - one lane shift register;
  - inputs: clk, rst, shift_en, clr, bit;
  - output: word.
  - Instantiated NUM_CH times via generate.
- The top level holds the shared counter, frame logic, output register and handshake.

Test Plan:
- NUM_CH=2, DATA_W=15, MSB_FIRST=1, ready_i=1: lane0 sends 0x5A5A MSB-first, lane1 sends 0x1234, with valid_i continuous → 1 clk after the 15th strobe, valid_o=1 for 1 cycle, data_o[14:0]=0x5A5A, data_o[29:15]=0x1234, word_cnt_o=1.
- MSB_FIRST=0, same bit sequence sent LSB-first on lane0 → data_o[14:0]=0x5A5A; valid_i gapped randomly 50% gives the identical result.
- Misalignment: frame_i at bit 0, then frame_i again at bit 6 → frame_err_o pulses once. The next word completes 15 strobes after the second frame_i and carries the correct value; nothing from the truncated word appears.
- Backpressure: ready_i=0, two consecutive words 0x0001 then 0x0002 → data_o holds 0x0001, overflow_o=1 and stays 1. Raising ready_i consumes 0x0001 and word_cnt_o=1.
- Accept-and-refill: valid_o=1, ready_i=1 in the exact cycle a new word 0x7FFF completes → valid_o stays 1, data_o=0x7FFF, overflow_o stays 0.
- Reset at bit 9 of a word → all outputs 0. The next 15 strobes after reset produce one clean word.
